// File: rtl/inst_fetch_stage.sv
// IF stage: boot-loads instruction RAM, then fetches at pc into a registered IF/ID word.
// Optional FETCH_STATS_EN adds fetch_count/squash_count outputs.
module inst_fetch_stage #(
  parameter int          ADDR_W  = 9,
  parameter logic [31:0] NOP     = 32'h00000013,
  parameter int          FLUSH_N = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        breakPipe,
  input  logic        stop,
  input  logic        pc_override,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        inst_misalign,
  output logic        boot_done,
`ifdef FETCH_STATS_EN
  output logic [31:0] fetch_count,
  output logic [31:0] squash_count,
`endif
  output logic [15:0] boot_count
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0]        state;
  logic [3:0]        flush_cnt;
  logic [31:0]       ram [2**ADDR_W];
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic              boot_wr;
  logic              unused_ok;

  assign wr_idx  = inst_addr[ADDR_W+1:2];
  assign rd_idx  = pc[ADDR_W+1:2];
  assign boot_wr = (state == S_BOOT) && pc_override;

  // address bits outside the RAM window are intentionally dropped
  assign unused_ok = ^{pc[31:ADDR_W+2], inst_addr[31:ADDR_W+2],
                       inst_addr[1:0]};

  always_ff @(posedge clk) begin
    if (boot_wr)
      ram[wr_idx] <= inst_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_BOOT;
      flush_cnt     <= 4'd0;
      inst          <= NOP;
      inst_pc       <= 32'd0;
      inst_valid    <= 1'b0;
      inst_misalign <= 1'b0;
      boot_done     <= 1'b0;
      boot_count    <= 16'd0;
`ifdef FETCH_STATS_EN
      fetch_count   <= 32'd0;
      squash_count  <= 32'd0;
`endif
    end else begin
      case (state)
        S_BOOT: begin
          if (pc_override) begin
            if (boot_count != 16'hFFFF)
              boot_count <= boot_count + 16'd1;
          end else begin
            state     <= S_FLUSH;
            flush_cnt <= 4'(FLUSH_N - 1);
          end
        end
        S_FLUSH: begin
          if (flush_cnt == 4'd0) begin
            state     <= S_RUN;
            boot_done <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        S_RUN: begin
          if (stop) begin
            inst <= inst;
          end else if (breakPipe) begin
            inst          <= NOP;
            inst_pc       <= pc;
            inst_valid    <= 1'b0;
            inst_misalign <= 1'b0;
`ifdef FETCH_STATS_EN
            squash_count  <= squash_count + 32'd1;
`endif
          end else begin
            inst          <= ram[rd_idx];
            inst_pc       <= pc;
            inst_valid    <= 1'b1;
            inst_misalign <= |pc[1:0];
`ifdef FETCH_STATS_EN
            fetch_count   <= fetch_count + 32'd1;
`endif
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Directed self-checking bench for inst_fetch_stage.
// Default build: ADDR_W=9, FLUSH_N=1.
module tb_inst_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] A0  = 32'hA0A0_0000;
  localparam logic [31:0] A1  = 32'hA1A1_1111;
  localparam logic [31:0] A2  = 32'hA2A2_2222;
  localparam logic [31:0] A3  = 32'hA3A3_3333;
  localparam logic [31:0] C5  = 32'hC5C5_5555;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        breakPipe;
  logic        stop;
  logic        pc_override;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_misalign;
  logic        boot_done;
  logic [15:0] boot_count;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] squash_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [65:0] got;
  logic [65:0] exp_v;

  always #5 clk = ~clk;

  inst_fetch_stage dut (
    .clk(clk),
    .reset(reset),
    .pc(pc),
    .breakPipe(breakPipe),
    .stop(stop),
    .pc_override(pc_override),
    .inst_addr(inst_addr),
    .inst_data(inst_data),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_valid(inst_valid),
    .inst_misalign(inst_misalign),
    .boot_done(boot_done),
`ifdef FETCH_STATS_EN
    .fetch_count(fetch_count),
    .squash_count(squash_count),
`endif
    .boot_count(boot_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pc = 0; breakPipe = 0; stop = 0;
    pc_override = 0; inst_addr = 0; inst_data = 0;
    #12;
    got   = {inst, inst_pc, inst_valid, inst_misalign};
    exp_v = {NOP, 32'd0, 1'b0, 1'b0};
    n_chk++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL reset_out got %h exp %h", got, exp_v);
    end
    n_chk++;
    if ({boot_done, boot_count} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_boot got %h exp 0", {boot_done, boot_count});
    end
    #2 reset = 1'b0;
  endtask

  task automatic test_boot();
    logic [31:0] d [4];
    d[0] = A0; d[1] = A1; d[2] = A2; d[3] = A3;
    for (int i = 0; i < 4; i++) begin
      pc_override = 1'b1;
      inst_addr = 32'(i * 4);
      inst_data = d[i];
      breakPipe = 1'b1;
      step();
    end
    pc_override = 1'b0;
    breakPipe = 1'b0;
    n_chk++;
    if (boot_count !== 16'd4) begin
      n_fail++;
      $display("FAIL boot_count got %0d exp 4", boot_count);
    end
    step();
    n_chk++;
    if ({boot_done, inst_valid, inst} !== {1'b0, 1'b0, NOP}) begin
      n_fail++;
      $display("FAIL flush_cycle got %b %b %h exp 0 0 %h",
               boot_done, inst_valid, inst, NOP);
    end
    step();
    n_chk++;
    if ({boot_done, inst_valid, inst, boot_count} !==
        {1'b1, 1'b0, NOP, 16'd4}) begin
      n_fail++;
      $display("FAIL boot_done got %b %b %h %0d exp 1 0 %h 4",
               boot_done, inst_valid, inst, boot_count, NOP);
    end
  endtask

  task automatic test_seq_fetch();
    logic [31:0] d [3];
    d[0] = A0; d[1] = A1; d[2] = A2;
    for (int i = 0; i < 3; i++) begin
      pc = 32'(i * 4);
      step();
      got   = {inst, inst_pc, inst_valid, inst_misalign};
      exp_v = {d[i], 32'(i * 4), 1'b1, 1'b0};
      n_chk++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL seq%0d got %h exp %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_squash();
    pc = 32'd8; breakPipe = 1'b1;
    step();
    got   = {inst, inst_pc, inst_valid, inst_misalign};
    exp_v = {NOP, 32'd8, 1'b0, 1'b0};
    n_chk++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL squash got %h exp %h", got, exp_v);
    end
    pc = 32'd12; breakPipe = 1'b0;
    step();
    got   = {inst, inst_pc, inst_valid, inst_misalign};
    exp_v = {A3, 32'd12, 1'b1, 1'b0};
    n_chk++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL squash_resume got %h exp %h", got, exp_v);
    end
  endtask

  task automatic test_stall();
    exp_v = {A3, 32'd12, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      stop = 1'b1;
      pc = (i == 0) ? 32'd4 : 32'd8;
      breakPipe = (i == 2);
      step();
      got = {inst, inst_pc, inst_valid, inst_misalign};
      n_chk++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL stall%0d got %h exp %h", i, got, exp_v);
      end
    end
    stop = 1'b0; breakPipe = 1'b0; pc = 32'd4;
    step();
    got   = {inst, inst_pc, inst_valid, inst_misalign};
    exp_v = {A1, 32'd4, 1'b1, 1'b0};
    n_chk++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL stall_release got %h exp %h", got, exp_v);
    end
  endtask

  task automatic test_wrap_misalign();
    pc = 32'h0000_0804;
    step();
    got   = {inst, inst_pc, inst_valid, inst_misalign};
    exp_v = {A1, 32'h804, 1'b1, 1'b0};
    n_chk++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL wrap got %h exp %h", got, exp_v);
    end
    pc = 32'h0000_0006;
    step();
    got   = {inst, inst_pc, inst_valid, inst_misalign};
    exp_v = {A1, 32'h6, 1'b1, 1'b1};
    n_chk++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL misalign got %h exp %h", got, exp_v);
    end
  endtask

  task automatic test_override_in_run();
    pc_override = 1'b1; inst_addr = 32'd0; inst_data = 32'hDEAD_BEEF;
    pc = 32'd8;
    step();
    pc_override = 1'b0; pc = 32'd0;
    step();
    n_chk++;
    if ({inst, boot_count} !== {A0, 16'd4}) begin
      n_fail++;
      $display("FAIL override_run got %h %0d exp %h 4", inst, boot_count, A0);
    end
  endtask

  task automatic test_async_reset();
    #2 reset = 1'b1;
    #1;
    got   = {inst, inst_pc, inst_valid, inst_misalign};
    exp_v = {NOP, 32'd0, 1'b0, 1'b0};
    n_chk++;
    if (got !== exp_v || boot_done !== 1'b0 || boot_count !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset got %h %b %0d exp %h 0 0",
               got, boot_done, boot_count, exp_v);
    end
    #1 reset = 1'b0;
    pc_override = 1'b1; inst_addr = 32'hFFFF_FFFC; inst_data = C5;
    step();
    pc_override = 1'b0;
    step();
    step();
    n_chk++;
    if ({boot_done, boot_count} !== {1'b1, 16'd1}) begin
      n_fail++;
      $display("FAIL reboot got %b %0d exp 1 1", boot_done, boot_count);
    end
    pc = 32'd0;
    step();
    n_chk++;
    if ({inst, inst_valid} !== {A0, 1'b1}) begin
      n_fail++;
      $display("FAIL ram_retain got %h %b exp %h 1", inst, inst_valid, A0);
    end
    pc = 32'hFFFF_FFFC;
    step();
    n_chk++;
    if ({inst, inst_pc} !== {C5, 32'hFFFF_FFFC}) begin
      n_fail++;
      $display("FAIL top_word got %h %h exp %h fffffffc", inst, inst_pc, C5);
    end
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats();
    n_chk++;
    if ({fetch_count, squash_count} !== {32'd2, 32'd0}) begin
      n_fail++;
      $display("FAIL stats got %0d %0d exp 2 0", fetch_count, squash_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_boot();
    test_seq_fetch();
    test_squash();
    test_stall();
    test_wrap_misalign();
    test_override_in_run();
    test_async_reset();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
